// File: rtl/pe_ctx_seq_if.sv
// Bus bundle for pe_ctx_seq: config load port, run/done handshake and neighbour/LSU data.
// The master side drives configuration and data inputs; the slave side is the PE.
interface pe_ctx_seq_if #(
    parameter int DW   = 32,
    parameter int NREG = 4,
    parameter int NCTX = 8
);
    localparam int CW = $clog2(NCTX);
    localparam int IW = 36 + NREG;

    logic          cfg_we;
    logic [CW-1:0] cfg_addr;
    logic [IW-1:0] cfg_data;
    logic [CW-1:0] ctx_last;
    logic [15:0]   iter_num;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] ctx;
    logic [DW-1:0] din_N, din_S, din_W, din_E, din_LSU;
    logic [DW-1:0] dout_N, dout_S, dout_W, dout_E, dout_LSU;
    logic          dout_vld;

    modport master (
        output cfg_we, cfg_addr, cfg_data, ctx_last, iter_num, start,
        output din_N, din_S, din_W, din_E, din_LSU,
        input  busy, done, ctx, dout_N, dout_S, dout_W, dout_E, dout_LSU, dout_vld
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, ctx_last, iter_num, start,
        input  din_N, din_S, din_W, din_E, din_LSU,
        output busy, done, ctx, dout_N, dout_S, dout_W, dout_E, dout_LSU, dout_vld
    );
endinterface

// File: rtl/pe_ctx_seq.sv
// Multi-context CGRA processing element: NCTX stored instructions stepped once per clock
// for a programmed number of loop iterations, with routing, register file and registered FU.
module pe_ctx_seq #(
    parameter int DW   = 32,
    parameter int NREG = 4,
    parameter int NCTX = 8
) (
    input  logic         clk,
    input  logic         rst,
    pe_ctx_seq_if.slave  bus
);
    localparam int CW = $clog2(NCTX);
    localparam int IW = 36 + NREG;
    localparam int SW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        ctx_q, ctx_d;
    logic [CW-1:0]        last_q, last_d;
    logic [15:0]          iter_q, iter_d;
    logic signed [DW-1:0] res_q, res_d;
    logic signed [DW-1:0] rf_q [NREG];
    logic signed [DW-1:0] rf_d [NREG];
    logic [IW-1:0]        mem_q [NCTX];
    logic [IW-1:0]        mem_d [NCTX];

    logic [IW-1:0]        inst;
    logic [3:0]           op, src_a, src_b, sel_n, sel_s, sel_w, sel_e, sel_lsu, rf_src;
    logic [NREG-1:0]      rf_we;
    logic signed [DW-1:0] src [16];
    logic signed [DW-1:0] fu_res;
    logic                 run;

    function automatic logic signed [DW-1:0] fu_eval(
        input logic [3:0]           f_op,
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic [SW-1:0] sh;
        sh = b[SW-1:0];
        case (f_op)
            4'd0:    return a;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a * b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a << sh;
            4'd8:    return $signed($unsigned(a) >> sh);
            4'd9:    return a >>> sh;
            4'd10:   return (a < b) ? {{(DW-1){1'b0}}, 1'b1} : '0;
            4'd11:   return (a == b) ? {{(DW-1){1'b0}}, 1'b1} : '0;
            4'd12:   return (a < b) ? a : b;
            4'd13:   return (a < b) ? b : a;
            default: return '0;
        endcase
    endfunction

    assign inst    = mem_q[ctx_q];
    assign op      = inst[IW-1  -: 4];
    assign src_a   = inst[IW-5  -: 4];
    assign src_b   = inst[IW-9  -: 4];
    assign sel_n   = inst[IW-13 -: 4];
    assign sel_s   = inst[IW-17 -: 4];
    assign sel_w   = inst[IW-21 -: 4];
    assign sel_e   = inst[IW-25 -: 4];
    assign sel_lsu = inst[IW-29 -: 4];
    assign rf_src  = inst[IW-33 -: 4];
    assign rf_we   = inst[NREG-1:0];

    // Source table indexed directly by the 4-bit select code; unused codes stay zero.
    always_comb begin
        for (int i = 0; i < 16; i++) src[i] = '0;
        src[0] = bus.din_N;
        src[1] = bus.din_S;
        src[2] = bus.din_W;
        src[3] = bus.din_E;
        src[4] = bus.din_LSU;
        src[5] = res_q;
        for (int i = 0; i < NREG; i++) src[8+i] = rf_q[i];
    end

    assign run    = (state_q == RUN);
    assign fu_res = fu_eval(op, src[src_a], src[src_b]);

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.dout_vld = run;
    assign bus.ctx      = ctx_q;
    assign bus.dout_N   = run ? src[sel_n]   : '0;
    assign bus.dout_S   = run ? src[sel_s]   : '0;
    assign bus.dout_W   = run ? src[sel_w]   : '0;
    assign bus.dout_E   = run ? src[sel_e]   : '0;
    assign bus.dout_LSU = run ? src[sel_lsu] : '0;

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        last_d  = last_q;
        iter_d  = iter_q;
        res_d   = res_q;
        rf_d    = rf_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                // A write and a start on the same edge: the write lands before the first RUN fetch.
                if (bus.cfg_we && (32'(bus.cfg_addr) < NCTX))
                    mem_d[bus.cfg_addr] = bus.cfg_data;
                if (bus.start) begin
                    last_d  = (32'(bus.ctx_last) > NCTX - 1) ? CW'(NCTX - 1) : bus.ctx_last;
                    iter_d  = bus.iter_num;
                    ctx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = fu_res;
                for (int i = 0; i < NREG; i++)
                    if (rf_we[i]) rf_d[i] = src[rf_src];
                if (ctx_q == last_q) begin
                    ctx_d = '0;
                    if (iter_q == '0) state_d = DONE;
                    else              iter_d  = iter_q - 16'd1;
                end else begin
                    ctx_d = ctx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ctx_q   <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            res_q   <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i]  <= '0;
            for (int i = 0; i < NCTX; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
            rf_q    <= rf_d;
            mem_q   <= mem_d;
        end
    end
endmodule
